// File: rtl/nibble_pkg.sv
// nibble_pkg: shared types for the nibble CPU control block.
// Opcode map, ALU operation codes, sequencer states and the decoded
// control word passed from nibble_decode to nibble_control.
package nibble_pkg;

  typedef enum logic [3:0] {
    OP_JC    = 4'h0,
    OP_JNC   = 4'h1,
    OP_CMPI  = 4'h2,
    OP_CMPM  = 4'h3,
    OP_LIT   = 4'h4,
    OP_IN    = 4'h5,
    OP_LD    = 4'h6,
    OP_ST    = 4'h7,
    OP_JZ    = 4'h8,
    OP_JNZ   = 4'h9,
    OP_ADDI  = 4'hA,
    OP_ADDM  = 4'hB,
    OP_JMP   = 4'hC,
    OP_OUT   = 4'hD,
    OP_NANDI = 4'hE,
    OP_NANDM = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_NAND   = 2'b10,
    ALU_PASS_B = 2'b11
  } alu_op_e;

  // IDLE is only reachable when NIBBLE_CTRL_RUN_EN is defined.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  // Everything the EXEC cycle needs to know about one instruction.
  typedef struct packed {
    alu_op_e alu_op;
    logic    b_sel;      // ALU B from RAM instead of the operand nibble
    logic    acc_we;
    logic    ram_we;
    logic    in_en;
    logic    out_we;
    logic    upd_carry;
    logic    upd_zero;
    logic    two_byte;   // instruction owns the next program byte
    logic    jump;       // jump resolved as taken with the current flags
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/nibble_control_if.sv
// nibble_control_if: control <-> datapath signal bundle for the nibble CPU.
// master = the control block, slave = the counter/ROM/ALU/RAM/IO side.
// NIBBLE_CTRL_RUN_EN adds the run request and halted status.
interface nibble_control_if;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [7:0]  program_byte;
  logic        alu_carry;
  logic        alu_zero;
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_addr;
  logic        fetch_en;
  logic [11:0] mem_addr;
  logic [1:0]  alu_op;
  logic        b_sel;
  logic        acc_we;
  logic        ram_we;
  logic        in_en;
  logic        out_we;
  logic        phase;
  logic        carry;
  logic        zero;
`ifdef NIBBLE_CTRL_RUN_EN
  logic        run;
  logic        halted;

  modport master (
    input  instr, oprnd, program_byte, alu_carry, alu_zero, run,
    output pc_inc, pc_load, pc_addr, fetch_en, mem_addr, alu_op, b_sel,
           acc_we, ram_we, in_en, out_we, phase, carry, zero, halted
  );
  modport slave (
    output instr, oprnd, program_byte, alu_carry, alu_zero, run,
    input  pc_inc, pc_load, pc_addr, fetch_en, mem_addr, alu_op, b_sel,
           acc_we, ram_we, in_en, out_we, phase, carry, zero, halted
  );
`else
  modport master (
    input  instr, oprnd, program_byte, alu_carry, alu_zero,
    output pc_inc, pc_load, pc_addr, fetch_en, mem_addr, alu_op, b_sel,
           acc_we, ram_we, in_en, out_we, phase, carry, zero
  );
  modport slave (
    output instr, oprnd, program_byte, alu_carry, alu_zero,
    input  pc_inc, pc_load, pc_addr, fetch_en, mem_addr, alu_op, b_sel,
           acc_we, ram_we, in_en, out_we, phase, carry, zero
  );
`endif
endinterface

// File: rtl/nibble_decode.sv
// nibble_decode: purely combinational opcode + flags -> control word.
// Conditional jumps are resolved here against the flags held before
// the current EXEC cycle.
module nibble_decode
  import nibble_pkg::*;
(
  input  logic [3:0] instr,
  input  logic       carry,
  input  logic       zero,
  output ctrl_t      ctrl
);

  // Map each opcode onto its strobes and jump decision.
  always_comb begin
    // NOTE: assigning a full default first keeps every field driven on every path, so no latch is inferred.
    ctrl = CTRL_NOP;
    unique case (opcode_e'(instr))
      OP_JC:    begin ctrl.two_byte = 1'b1; ctrl.jump = carry; end
      OP_JNC:   begin ctrl.two_byte = 1'b1; ctrl.jump = !carry; end
      OP_CMPI:  begin ctrl.alu_op = ALU_SUB; ctrl.upd_carry = 1'b1; ctrl.upd_zero = 1'b1; end
      OP_CMPM:  begin
        ctrl.alu_op = ALU_SUB; ctrl.b_sel = 1'b1; ctrl.two_byte = 1'b1;
        ctrl.upd_carry = 1'b1; ctrl.upd_zero = 1'b1;
      end
      OP_LIT:   begin ctrl.alu_op = ALU_PASS_B; ctrl.acc_we = 1'b1; end
      OP_IN:    begin ctrl.alu_op = ALU_PASS_B; ctrl.in_en = 1'b1; ctrl.acc_we = 1'b1; end
      OP_LD:    begin
        ctrl.alu_op = ALU_PASS_B; ctrl.b_sel = 1'b1; ctrl.acc_we = 1'b1; ctrl.two_byte = 1'b1;
      end
      OP_ST:    begin ctrl.ram_we = 1'b1; ctrl.two_byte = 1'b1; end
      OP_JZ:    begin ctrl.two_byte = 1'b1; ctrl.jump = zero; end
      OP_JNZ:   begin ctrl.two_byte = 1'b1; ctrl.jump = !zero; end
      OP_ADDI:  begin
        ctrl.alu_op = ALU_ADD; ctrl.acc_we = 1'b1; ctrl.upd_carry = 1'b1; ctrl.upd_zero = 1'b1;
      end
      OP_ADDM:  begin
        ctrl.alu_op = ALU_ADD; ctrl.b_sel = 1'b1; ctrl.acc_we = 1'b1; ctrl.two_byte = 1'b1;
        ctrl.upd_carry = 1'b1; ctrl.upd_zero = 1'b1;
      end
      OP_JMP:   begin ctrl.two_byte = 1'b1; ctrl.jump = 1'b1; end
      OP_OUT:   begin ctrl.out_we = 1'b1; end
      OP_NANDI: begin ctrl.alu_op = ALU_NAND; ctrl.acc_we = 1'b1; ctrl.upd_zero = 1'b1; end
      OP_NANDM: begin
        ctrl.alu_op = ALU_NAND; ctrl.b_sel = 1'b1; ctrl.acc_we = 1'b1; ctrl.two_byte = 1'b1;
        ctrl.upd_zero = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/nibble_control.sv
// nibble_control: FETCH/EXEC phase sequencer, flag register and strobe
// gating for the nibble CPU. Strobes are forced low in any cycle where
// reset is high, so a reset landing on EXEC never commits a write or a
// PC move. NIBBLE_CTRL_RUN_EN adds run/halted and an IDLE state.
module nibble_control
  import nibble_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  nibble_control_if.master bus
);

  state_e state_q, state_d;
  logic   carry_q, zero_q;
  ctrl_t  dec;

  logic        pc_inc, pc_load, fetch_en, b_sel, acc_we, ram_we, in_en, out_we;
  logic [1:0]  alu_op;
  logic        run_req;
  state_e      reset_state;

`ifdef NIBBLE_CTRL_RUN_EN
  assign run_req     = bus.run;
  assign reset_state = bus.run ? ST_FETCH : ST_IDLE;
  assign bus.halted  = (state_q == ST_IDLE);
`else
  assign run_req     = 1'b1;
  assign reset_state = ST_FETCH;
`endif

  nibble_decode u_decode (
    .instr (bus.instr),
    .carry (carry_q),
    .zero  (zero_q),
    .ctrl  (dec)
  );

  // Phase register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) state_q <= reset_state;
    else       state_q <= state_d;
  end

  // Next phase and the strobes for the current phase.
  always_comb begin
    state_d  = state_q;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    fetch_en = 1'b0;
    alu_op   = ALU_ADD;
    b_sel    = 1'b0;
    acc_we   = 1'b0;
    ram_we   = 1'b0;
    in_en    = 1'b0;
    out_we   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_EXEC;
        if (!reset) begin
          fetch_en = 1'b1;
          pc_inc   = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d = run_req ? ST_FETCH : ST_IDLE;
        if (!reset) begin
          alu_op  = dec.alu_op;
          b_sel   = dec.b_sel;
          acc_we  = dec.acc_we;
          ram_we  = dec.ram_we;
          in_en   = dec.in_en;
          out_we  = dec.out_we;
          pc_load = dec.jump;
          pc_inc  = dec.two_byte && !dec.jump;
        end
      end
      ST_IDLE: state_d = run_req ? ST_FETCH : ST_IDLE;
      default: state_d = ST_FETCH;
    endcase
  end

  // Carry/zero capture at the end of flag-setting EXEC cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      if (dec.upd_carry) carry_q <= bus.alu_carry;
      if (dec.upd_zero)  zero_q  <= bus.alu_zero;
    end
  end

  assign bus.pc_inc   = pc_inc;
  assign bus.pc_load  = pc_load;
  assign bus.fetch_en = fetch_en;
  assign bus.alu_op   = alu_op;
  assign bus.b_sel    = b_sel;
  assign bus.acc_we   = acc_we;
  assign bus.ram_we   = ram_we;
  assign bus.in_en    = in_en;
  assign bus.out_we   = out_we;
  assign bus.pc_addr  = {bus.oprnd, bus.program_byte};
  assign bus.mem_addr = {bus.oprnd, bus.program_byte};
  assign bus.phase    = (state_q == ST_EXEC);
  assign bus.carry    = carry_q;
  assign bus.zero     = zero_q;

endmodule

// File: doc/nibble_control.md
# nibble_control

Phase sequencer and instruction decoder for the 4-bit nibble CPU; the consuming end of the program-counter / program-ROM / fetch-register path. It drives the counter's load/enable and the fetch register's enable, and takes back the fetched instruction/operand nibbles and the raw program byte. It decodes each instruction into datapath strobes (ALU, accumulator, RAM, I/O), owns the carry/zero flags, and resolves conditional jumps.

## Interface
- No parameters; widths fixed: 4-bit opcode/operand, 8-bit program byte, 12-bit address.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- instr  in  4  opcode nibble from fetch register
- oprnd  in  4  operand nibble from fetch register
- program_byte  in  8  current ROM output (byte at PC)
- alu_carry  in  1  ALU carry-out for the current op
- alu_zero  in  1  ALU result == 0
- pc_inc  out  1  counter enable (increment)
- pc_load  out  1  counter load
- pc_addr  out  12  counter load value {oprnd, program_byte}
- fetch_en  out  1  fetch register enable
- mem_addr  out  12  RAM address {oprnd, program_byte}
- alu_op  out  2  00 ADD, 01 SUB, 10 NAND, 11 PASS_B
- b_sel  out  1  ALU B source: 0 = oprnd immediate, 1 = RAM data
- acc_we  out  1  accumulator write
- ram_we  out  1  RAM write (accumulator -> RAM)
- in_en  out  1  input port drives ALU B (PASS_B)
- out_we  out  1  output port latches accumulator
- phase  out  1  0 = FETCH, 1 = EXEC
- carry, zero  out  1 each  flag register values

## Operation
- Two-state FSM: FETCH -> EXEC -> FETCH.
- FETCH: fetch_en=1, pc_inc=1; all other strobes 0.
- EXEC: decode instr; operand/byte-2 combinational from inputs; strobes valid the whole cycle.
- Opcode map: 0 JC, 1 JNC, 2 CMPI, 3 CMPM, 4 LIT, 5 IN, 6 LD, 7 ST, 8 JZ, 9 JNZ, A ADDI, B ADDM, C JMP, D OUT, E NANDI, F NANDM.
- Two-byte ops (0,1,3,6,7,8,9,B,C,F): second byte is program_byte during EXEC. Taken jump -> pc_load=1, pc_addr={oprnd,program_byte}; otherwise pc_inc=1 to skip byte 2. pc_load and pc_inc never both 1.
- JMP always taken; JC/JNC test carry; JZ/JNZ test zero (flag values held before this EXEC).
- CMPI/CMPM: alu_op=SUB, flags update, acc_we=0.
- ADDI/ADDM: ADD, acc_we=1, flags update. NANDI/NANDM: NAND, acc_we=1, zero updates, carry held.
- LIT: PASS_B, b_sel=0, acc_we=1. LD: PASS_B, b_sel=1, acc_we=1. IN: PASS_B, in_en=1, acc_we=1. Flags unchanged.
- ST: ram_we=1. OUT: out_we=1.
- "M" variants set b_sel=1 and mem_addr={oprnd,program_byte}; immediates set b_sel=0.
- Flag update: carry<=alu_carry, zero<=alu_zero at end of EXEC.

## Timing
- Reset: state FETCH, carry=0, zero=0; synchronously all strobes 0 in the reset cycle, including fetch_en/pc_inc.
- First fetch occurs in the first cycle after reset deasserts.
- Every instruction takes exactly 2 cycles; jump target byte fetched in the FETCH following EXEC.
- Flags written in EXEC are visible to the next instruction's EXEC.
- Reset asserted during EXEC: no acc_we/ram_we/out_we/pc action that cycle; FSM to FETCH.
- pc_addr 0xFFF load and counter wrap at 0xFFF->0x000 are legal, no special handling.

## Configuration
- NIBBLE_CTRL_RUN_EN defined: adds input run (1) and output halted (1). FETCH is entered only when run=1; with run=0 after EXEC completes, FSM sits in an IDLE state with all strobes 0 and halted=1. run deasserting mid-instruction never aborts EXEC. Reset -> IDLE if run=0.
- Undefined: no run/halted ports, no IDLE state, free-running FETCH/EXEC.

## Structure
- nibble_pkg: opcode enum, alu_op enum (ADD/SUB/NAND/PASS_B), FSM state enum, control-word struct.
- Sub-module nibble_decode: combinational instr + flags -> control word; nibble_control holds FSM, flag register, strobe gating.

## Test plan
- Reset released, instr=4 oprnd=7 -> cycle 1 fetch_en=pc_inc=1; cycle 2 acc_we=1, alu_op=PASS_B, b_sel=0, no PC action.
- JMP instr=C oprnd=3 program_byte=0x45 in EXEC -> pc_load=1, pc_addr=0x345, pc_inc=0.
- ADDI with alu_carry=1 then JC oprnd=1 byte=0x00 -> carry=1, pc_load=1 addr 0x100; repeat with carry=0 -> pc_inc=1, pc_load=0.
- ST instr=7 oprnd=2 byte=0x10 -> ram_we=1, mem_addr=0x210, acc_we=0, pc_inc=1.
- CMPI with alu_zero=1 then JNZ -> acc_we=0 on CMPI, zero=1, JNZ not taken (pc_inc=1).
- Reset during EXEC of ST -> ram_we=0 that cycle; next cycle FETCH with carry=zero=0.
